// File: rtl/gate_seq_ctrl_pkg.sv
// Shared constants for the two-sensor gate controller: FSM state encoding
// and default counter geometry.
package gate_seq_ctrl_pkg;

  localparam int DEF_CNT_W       = 4;
  localparam int DEF_MAX_CNT     = 9;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_E1   = 3'd1;
  localparam logic [2:0] S_E2   = 3'd2;
  localparam logic [2:0] S_E3   = 3'd3;
  localparam logic [2:0] S_X1   = 3'd4;
  localparam logic [2:0] S_X2   = 3'd5;
  localparam logic [2:0] S_X3   = 3'd6;

endpackage

// File: rtl/gate_seq_ctrl_if.sv
// Sensor inputs and occupancy/event outputs of the gate controller.
// master = sensor/application side, slave = controller side.
interface gate_seq_ctrl_if
  import gate_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             a;
  logic             b;
  logic [CNT_W-1:0] num;
  logic             out;
  logic             inc_p;
  logic             dec_p;
  logic             err_p;

  modport master (output a, b, input num, out, inc_p, dec_p, err_p);
  modport slave  (input a, b, output num, out, inc_p, dec_p, err_p);
endinterface

// File: rtl/gate_seq_ctrl_sync.sv
// gate_sync: SYNC_STAGES-deep flop chain bringing one asynchronous sensor
// level into the clk domain.
module gate_sync
  import gate_seq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/gate_seq_ctrl.sv
// Two-sensor gate sequencer: decodes entry/exit traversals and keeps a
// saturating occupancy count. Define GATE_TIMEOUT_EN to add the stall timeout.
module gate_seq_ctrl
  import gate_seq_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_CNT     = DEF_MAX_CNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic            clk,
  input  logic            rst,
  gate_seq_ctrl_if.slave  bus
);
  if (MAX_CNT >= (1 << CNT_W) || SYNC_STAGES < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("gate_seq_ctrl: illegal parameter set");
  end

  logic             w_as, w_bs;
  logic [1:0]       w_ab;
  logic [2:0]       r_state, w_nxt, w_state_d;
  logic             w_ent, w_ext, w_ill, w_to;
  logic             w_full, w_empty, w_inc_ok, w_dec_ok, w_err;
  logic [CNT_W-1:0] r_num, w_num_d;
  logic             r_out, r_inc, r_dec, r_err;

  gate_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst(rst), .i_d(bus.a), .o_q(w_as));
  gate_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst(rst), .i_d(bus.b), .o_q(w_bs));

  assign w_ab = {w_as, w_bs};

  // Exit states mirror entry states with the a/b roles swapped.
  always_comb begin
    w_nxt = r_state;
    w_ent = 1'b0;
    w_ext = 1'b0;
    w_ill = 1'b0;
    case (r_state)
      S_IDLE: case (w_ab)
        2'b10: w_nxt = S_E1;
        2'b01: w_nxt = S_X1;
        2'b11: w_ill = 1'b1;
        default: ;
      endcase
      S_E1: case (w_ab)
        2'b11: w_nxt = S_E2;
        2'b00: w_nxt = S_IDLE;
        2'b01: begin w_nxt = S_IDLE; w_ill = 1'b1; end
        default: ;
      endcase
      S_E2: case (w_ab)
        2'b01: w_nxt = S_E3;
        2'b10: w_nxt = S_E1;
        2'b00: begin w_nxt = S_IDLE; w_ill = 1'b1; end
        default: ;
      endcase
      S_E3: case (w_ab)
        2'b00: begin w_nxt = S_IDLE; w_ent = 1'b1; end
        2'b11: w_nxt = S_E2;
        2'b10: begin w_nxt = S_IDLE; w_ill = 1'b1; end
        default: ;
      endcase
      S_X1: case (w_ab)
        2'b11: w_nxt = S_X2;
        2'b00: w_nxt = S_IDLE;
        2'b10: begin w_nxt = S_IDLE; w_ill = 1'b1; end
        default: ;
      endcase
      S_X2: case (w_ab)
        2'b10: w_nxt = S_X3;
        2'b01: w_nxt = S_X1;
        2'b00: begin w_nxt = S_IDLE; w_ill = 1'b1; end
        default: ;
      endcase
      S_X3: case (w_ab)
        2'b00: begin w_nxt = S_IDLE; w_ext = 1'b1; end
        2'b11: w_nxt = S_X2;
        2'b01: begin w_nxt = S_IDLE; w_ill = 1'b1; end
        default: ;
      endcase
      default: w_nxt = S_IDLE;
    endcase
  end

`ifdef GATE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] r_stall;
  logic            w_stalled;

  assign w_stalled = (r_state != S_IDLE) && (w_nxt == r_state);
  assign w_to      = w_stalled && (r_stall == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_stall <= '0;
    else if (w_stalled && !w_to) r_stall <= r_stall + 1'b1;
    else                       r_stall <= '0;
  end
`else
  assign w_to = 1'b0;
`endif

  // Completions at a saturated count are reported as errors instead.
  assign w_state_d = w_to ? S_IDLE : w_nxt;
  assign w_full    = (r_num == CNT_W'(MAX_CNT));
  assign w_empty   = (r_num == '0);
  assign w_inc_ok  = w_ent & ~w_full;
  assign w_dec_ok  = w_ext & ~w_empty;
  assign w_err     = w_ill | (w_ent & w_full) | (w_ext & w_empty) | w_to;
  assign w_num_d   = w_inc_ok ? r_num + 1'b1 : (w_dec_ok ? r_num - 1'b1 : r_num);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_out   <= 1'b0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_num   <= w_num_d;
      r_out   <= (w_num_d == CNT_W'(MAX_CNT));
      r_inc   <= w_inc_ok;
      r_dec   <= w_dec_ok;
      r_err   <= w_err;
    end
  end

  assign bus.num   = r_num;
  assign bus.out   = r_out;
  assign bus.inc_p = r_inc;
  assign bus.dec_p = r_dec;
  assign bus.err_p = r_err;
endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Self-checking bench for gate_seq_ctrl: directed vector table, hand-written
// reset/timeout sequences, and random stimulus against a path-position model.
module tb_gate_seq_ctrl;
  localparam int CNT_W = 4;
  localparam int MAXC  = 9;
  localparam int SYNC  = 2;
  localparam int TO    = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_seq_ctrl_if #(.CNT_W(CNT_W)) ifc ();

  gate_seq_ctrl #(.CNT_W(CNT_W), .MAX_CNT(MAXC), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO))
    dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: progress along the expected pattern path of the
  // current direction (+1 entry 10,11,01 / -1 exit 01,11,10), not FSM states.
  typedef struct {
    int dir;
    int step;
    int num;
    bit inc;
    bit dec;
    bit err;
    int stall;
  } mstate_t;

  function automatic mstate_t step_model(input mstate_t c, input logic [1:0] p);
    mstate_t n;
    logic [1:0] path [3];
    int pos;
    n = c;
    n.inc = 1'b0; n.dec = 1'b0; n.err = 1'b0;
    if (c.step == 0) begin
      if (p == 2'b10)      begin n.dir = 1;  n.step = 1; end
      else if (p == 2'b01) begin n.dir = -1; n.step = 1; end
      else if (p == 2'b11) n.err = 1'b1;
    end else begin
      if (c.dir > 0) begin path[0] = 2'b10; path[1] = 2'b11; path[2] = 2'b01; end
      else           begin path[0] = 2'b01; path[1] = 2'b11; path[2] = 2'b10; end
      pos = -1;
      if (p == 2'b00) pos = 0;
      for (int i = 0; i < 3; i++) if (path[i] == p) pos = i + 1;
      if (pos == c.step) ;
      else if (pos >= 1 && (pos - c.step == 1 || c.step - pos == 1)) n.step = pos;
      else if (pos == 0 && c.step == 1) n.step = 0;
      else if (pos == 0 && c.step == 3) begin
        n.step = 0;
        if (c.dir > 0) begin
          if (c.num == MAXC) n.err = 1'b1; else begin n.num = c.num + 1; n.inc = 1'b1; end
        end else begin
          if (c.num == 0) n.err = 1'b1; else begin n.num = c.num - 1; n.dec = 1'b1; end
        end
      end else begin
        n.step = 0; n.err = 1'b1;
      end
    end
`ifdef GATE_TIMEOUT_EN
    if (c.step != 0 && n.step == c.step) begin
      if (c.stall == TO - 1) begin n.step = 0; n.err = 1'b1; n.stall = 0; end
      else n.stall = c.stall + 1;
    end else n.stall = 0;
`endif
    if (n.step == 0) n.dir = 0;
    return n;
  endfunction

  mstate_t m = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 0};
  logic [SYNC-1:0][1:0] mpipe = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m     <= '{0, 0, 0, 1'b0, 1'b0, 1'b0, 0};
      mpipe <= '0;
    end else begin
      m     <= step_model(m, mpipe[SYNC-1]);
      mpipe <= {mpipe[SYNC-2:0], {ifc.a, ifc.b}};
    end
  end

  int c_inc = 0, c_dec = 0, c_err = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.inc_p) c_inc++;
      if (ifc.dec_p) c_dec++;
      if (ifc.err_p) c_err++;
      chk("model", {ifc.num, ifc.out, ifc.inc_p, ifc.dec_p, ifc.err_p},
          {CNT_W'(m.num), m.num == MAXC, m.inc, m.dec, m.err});
    end
  end

  typedef struct {
    logic [1:0] ab;
    int         hold;
    int         num;
    bit         full;
    int         inc;
    int         dec;
    int         err;
  } vec_t;

  vec_t vecs[$];
  int e_num = 0, e_inc = 0, e_dec = 0, e_err = 0;

  task automatic push(input logic [1:0] ab, input int hold);
    vecs.push_back('{ab, hold, e_num, e_num == MAXC, e_inc, e_dec, e_err});
  endtask

  task automatic add_entry();
    push(2'b10, 10); push(2'b11, 10); push(2'b01, 10);
    if (e_num == MAXC) e_err++; else begin e_num++; e_inc++; end
    push(2'b00, 10);
  endtask

  task automatic add_exit();
    push(2'b01, 10); push(2'b11, 10); push(2'b10, 10);
    if (e_num == 0) e_err++; else begin e_num--; e_dec++; end
    push(2'b00, 10);
  endtask

  task automatic drive(input logic [1:0] ab, input int cycles);
    {ifc.a, ifc.b} = ab;
    repeat (cycles) @(negedge clk);
  endtask

  int base_inc, base_err;

  initial begin
    ifc.a = 1'b0; ifc.b = 1'b0;

    add_entry();
    add_exit();
    add_exit();
    push(2'b10, 10); push(2'b00, 10);
    push(2'b10, 10); push(2'b11, 10); push(2'b10, 10); push(2'b11, 10); push(2'b01, 10);
    e_num++; e_inc++;
    push(2'b00, 10);
    push(2'b11, 1);
    e_err++;
    push(2'b00, 10);
    for (int i = 0; i < 8; i++) add_entry();
    add_entry();

    repeat (3) @(negedge clk);
    chk("reset_state", {ifc.num, ifc.out, ifc.inc_p, ifc.dec_p, ifc.err_p}, '0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ab, vecs[i].hold);
      #1;
      chk($sformatf("vec%0d_num", i),  ifc.num, vecs[i].num);
      chk($sformatf("vec%0d_full", i), ifc.out, vecs[i].full);
      chk($sformatf("vec%0d_inc", i),  c_inc,   vecs[i].inc);
      chk($sformatf("vec%0d_dec", i),  c_dec,   vecs[i].dec);
      chk($sformatf("vec%0d_err", i),  c_err,   vecs[i].err);
    end

    // Asynchronous reset while parked in E2 with a nonzero count.
    base_inc = c_inc;
    drive(2'b10, 10);
    drive(2'b11, 10);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_num", ifc.num, 0);
    chk("rst_mid_out", ifc.out, 0);
    {ifc.a, ifc.b} = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 10);
    chk("rst_no_pulse", c_inc, base_inc);
    chk("rst_num_after", ifc.num, 0);

    // Long stall in E1: one timeout when enabled, silent otherwise.
    base_err = c_err;
    drive(2'b10, 40);
    drive(2'b00, 10);
`ifdef GATE_TIMEOUT_EN
    chk("stall_err", c_err - base_err, 1);
`else
    chk("stall_err", c_err - base_err, 0);
`endif
    chk("stall_num", ifc.num, 0);

    for (int i = 0; i < 400; i++)
      drive(2'($urandom_range(0, 3)), $urandom_range(1, 6));
    drive(2'b00, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
